sha256_padder: RTL
==================

// Module: sha256_padder
// PURPOSE
// Message front-end for the SHA-256 core: accepts a message as a byte stream, applies FIPS 180-4
// padding (0x80 marker, zero fill, 64-bit big-endian bit length) and presents 512-bit blocks
// ready for the compression FSM. One block buffer; back-pressures the byte stream while a block waits.
// PARAMETERS
// LEN_W  32  width of internal byte counter; bit length = {zero-extend(count), 3'b000} into 64 bits
// PORTS
// clk        in   1    clock
// rst_n      in   1    synchronous reset, active low
// in_valid   in   1    byte beat valid
// in_ready   out  1    padder can accept a beat
// in_data    in   8    message byte
// in_vbyte   in   1    beat carries a byte (0 only legal with in_last: terminates, no data)
// in_last    in   1    final beat of message
// blk_valid  out  1    blk_data holds a complete block
// blk_ready  in   1    core accepts block
// blk_data   out  512  block, byte 0 of block in [511:504] (big-endian words)
// blk_first  out  1    block is first of its message (core loads INIT_HASH)
// blk_last   out  1    block is final of its message (core proceeds to digest)
// BEHAVIOUR
// - One clock, reset synchronous active-low. Reset: state S_ACC, byte index 0, byte count 0,
//   buffer all zero, in_ready=1, blk_valid=0, blk_first=1 (first-flag reg), blk_last=0.
// - Handshakes: beat transfers when in_valid&in_ready; block when blk_valid&blk_ready. blk_data,
//   blk_first, blk_last stable while blk_valid&!blk_ready. in_ready=1 only in S_ACC.
// - S_ACC: each accepted byte beat (in_vbyte=1) written at buffer byte idx, idx++, count++.
//   * idx reaches 64 and !in_last -> S_FULL (blk_last=0) next cycle.
//   * in_last: n = bytes in block after this beat (0..64). Same-cycle padding into buffer:
//     n<=55: byte n=0x80, bytes n+1..55 zero, bytes 56..63 = bit length -> S_FIN.
//     56<=n<=63: byte n=0x80, rest zero -> S_FIN_X (pad2_marker=0).
//     n==64: no marker in this block -> S_FIN_X (pad2_marker=1).
// - Latency: byte filling a block or last beat accepted in cycle t -> blk_valid=1 in cycle t+1.
// - S_FULL: blk_valid=1; on accept: buffer cleared, idx=0, first-flag<=0 -> S_ACC.
// - S_FIN_X: blk_valid=1, blk_last=0; on accept: build second block next edge (bytes 0..55 zero,
//   byte 0 = 0x80 if pad2_marker, bytes 56..63 = bit length), first-flag<=0 -> S_FIN.
// - S_FIN: blk_valid=1, blk_last=1; on accept: buffer cleared, idx=0, count=0, first-flag<=1 -> S_ACC.
// - blk_first = first-flag; for S_FIN_X's second block it is 0. Empty message (in_last,in_vbyte=0,
//   idx=0): single block 0x80 followed by zeros, length 0, blk_first=blk_last=1.
// - Bit length computed from count after final byte; count wraps mod 2^LEN_W (longer msgs unsupported).
// - No beats accepted while blk_valid; a block and a beat never transfer in the same cycle.
// - Reset mid-message or with blk_valid high: everything returns to reset values next edge; partial
//   message discarded, no block emitted.
// STRUCTURE
// - sha256_pkg gains: typedef enum logic [1:0] {S_ACC, S_FULL, S_FIN_X, S_FIN} pad_state_t;
//   localparam PAD_MARKER = 8'h80; localparam BLK_BYTES = 64; localparam LEN_FIELD_BYTE = 56.
// - Single module, no sub-modules; byte write/pad logic as a function in the module.
// TESTING
// - "abc" (3 bytes, last on 3rd), blk_ready=1 -> one block: word0 32'h61626380, words1..14 zero,
//   word15 32'h00000018, first=1,last=1; core digest ba7816bf...f20015ad.
// - Empty message (single beat in_last=1,in_vbyte=0) -> word0 32'h80000000, rest 0, first=last=1.
// - 55 bytes 0x61 -> one block, byte55=0x80, word15 32'h000001B8; 56 bytes -> two blocks: first
//   byte56=0x80 last=0, second all zero except word15 32'h000001C0, first=0,last=1.
// - 64 bytes -> block1 pure data (last=0, in_ready=0 until accept), block2 word0 32'h80000000,
//   word15 32'h00000200; 65 bytes -> 2 blocks, second byte0=data, byte1=0x80, word15 32'h208.
// - Back-pressure: hold blk_ready=0 10 cycles -> blk_data/flags stable, in_ready=0, no beats lost;
//   back-to-back messages "abc","abc" -> both blocks first=last=1 and identical.
// - Assert rst_n=0 after 20 of 40 bytes and while blk_valid=1 -> outputs at reset values next
//   cycle; following "abc" gives the exact block from scenario 1.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and constants for the message padder.
package sha256_pkg;

  typedef enum logic [1:0] {S_ACC, S_FULL, S_FIN_X, S_FIN} pad_state_t;

  localparam logic [7:0]  PAD_MARKER     = 8'h80;
  localparam int unsigned BLK_BYTES      = 64;
  localparam int unsigned LEN_FIELD_BYTE = 56;

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks with
// 0x80 marker, zero fill and 64-bit big-endian bit length.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_vbyte,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  pad_state_t       state_q, state_d;
  logic [6:0]       idx_q, idx_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [511:0]     buf_q, buf_d;
  logic             first_q, first_d;
  logic             pad2_q, pad2_d;
  logic             in_ready_q, in_ready_d;
  logic             blk_valid_q, blk_valid_d;
  logic             blk_last_q, blk_last_d;

  logic [6:0]       beat_idx;
  logic [LEN_W-1:0] beat_cnt;
  logic [511:0]     beat_buf;
  logic [63:0]      beat_bitlen;
  logic [63:0]      held_bitlen;

  // Write one byte at block position pos (byte 0 in the top bits).
  function automatic logic [511:0] put_byte(input logic [511:0] blk,
                                            input int unsigned  pos,
                                            input logic [7:0]   b);
    logic [511:0] r;
    r = blk;
    r[511 - 8*pos -: 8] = b;
    return r;
  endfunction

  // Place marker at byte n, zero everything after it, and append the length
  // field only when it still fits (n below the length field). n==64 leaves
  // the block untouched.
  function automatic logic [511:0] pad_fill(input logic [511:0] blk,
                                            input int unsigned  n,
                                            input logic [63:0]  bitlen);
    logic [511:0] r;
    r = blk;
    for (int unsigned i = 0; i < BLK_BYTES; i++) begin
      if (i == n) begin
        r[511 - 8*i -: 8] = PAD_MARKER;
      end else if (i > n) begin
        r[511 - 8*i -: 8] = '0;
      end
      if (n < LEN_FIELD_BYTE && i >= LEN_FIELD_BYTE) begin
        r[511 - 8*i -: 8] = bitlen[63 - 8*(i - LEN_FIELD_BYTE) -: 8];
      end
    end
    return r;
  endfunction

  // Next-state, buffer update and registered output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    first_d     = first_q;
    pad2_d      = pad2_q;

    beat_idx    = idx_q + 7'(in_vbyte);
    beat_cnt    = cnt_q + LEN_W'(in_vbyte);
    beat_buf    = in_vbyte ? put_byte(buf_q, 32'(idx_q), in_data) : buf_q;
    beat_bitlen = 64'({beat_cnt, 3'b000});
    held_bitlen = 64'({cnt_q, 3'b000});

    case (state_q)
      S_ACC: begin
        if (in_valid) begin
          idx_d = beat_idx;
          cnt_d = beat_cnt;
          buf_d = beat_buf;
          if (in_last) begin
            buf_d = pad_fill(beat_buf, 32'(beat_idx), beat_bitlen);
            if (beat_idx < 7'(LEN_FIELD_BYTE)) begin
              state_d = S_FIN;
            end else begin
              state_d = S_FIN_X;
              pad2_d  = (beat_idx == 7'(BLK_BYTES));
            end
          end else if (beat_idx == 7'(BLK_BYTES)) begin
            state_d = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (blk_ready) begin
          buf_d   = '0;
          idx_d   = '0;
          first_d = 1'b0;
          state_d = S_ACC;
        end
      end
      S_FIN_X: begin
        // Overflow block: length field only, marker too if it did not fit before.
        if (blk_ready) begin
          buf_d        = '0;
          buf_d[63:0]  = held_bitlen;
          if (pad2_q) begin
            buf_d[511:504] = PAD_MARKER;
          end
          first_d = 1'b0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (blk_ready) begin
          buf_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          first_d = 1'b1;
          state_d = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase

    in_ready_d  = (state_d == S_ACC);
    blk_valid_d = (state_d != S_ACC);
    blk_last_d  = (state_d == S_FIN);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_ACC;
      idx_q       <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      first_q     <= 1'b1;
      pad2_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      blk_valid_q <= 1'b0;
      blk_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      first_q     <= first_d;
      pad2_q      <= pad2_d;
      in_ready_q  <= in_ready_d;
      blk_valid_q <= blk_valid_d;
      blk_last_q  <= blk_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign blk_valid = blk_valid_q;
  assign blk_last  = blk_last_q;
  assign blk_first = first_q;
  assign blk_data  = buf_q;

endmodule
